// File: rtl/vend_pkg.sv
// Shared constants for the vending transaction controller: one-hot state codes
// and coin values expressed in half-units.
package vend_pkg;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_COLLECT = 4'b0010;
  localparam logic [3:0] ST_VEND    = 4'b0100;
  localparam logic [3:0] ST_CHANGE  = 4'b1000;

  localparam int unsigned HALF_UNITS = 1;
  localparam int unsigned ONE_UNITS  = 2;

endpackage

// File: rtl/vend_wdog.sv
// Dispense watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
// Only instantiated when VEND_TIMEOUT_EN is defined.
module vend_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expiry fires on the edge that would complete the TIMEOUT-th counted cycle.
  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, dispenser handshake, change return.
// Define VEND_TIMEOUT_EN to add a dispense watchdog that refunds on timeout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE   = 3,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_half,
  input  logic          coin_one,
  input  logic          cancel,
  input  logic          dispense_ack,
  output logic          dispense_req,
  output logic          change_pulse,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          dispense_fault
);

  if (PRICE < 1 || PRICE > 13 || (PRICE + 1) >= (1 << CW) || TIMEOUT < 1) begin : g_param_chk
    $error("vend_ctrl: illegal parameter set");
  end

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          req_q, req_d;
  logic          pulse_q, pulse_d;
  logic          reject_q, reject_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic          coin_any, coin_both;
  logic [CW-1:0] coin_val, credit_acc, remainder;
  logic          wdog_expire;

`ifdef VEND_TIMEOUT_EN
  vend_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk),
    .rst_n_i  (rst),
    .clr_i    (state_q != ST_VEND),
    .en_i     (state_q == ST_VEND),
    .expire_o (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  assign coin_any  = coin_half | coin_one;
  assign coin_both = coin_half & coin_one;
  assign coin_val  = coin_both ? '0 :
                     coin_one  ? CW'(ONE_UNITS) :
                     coin_half ? CW'(HALF_UNITS) : '0;
  assign credit_acc = credit_q + coin_val;
  assign remainder  = credit_q - PRICE_C;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    req_d    = req_q;
    pulse_d  = 1'b0;
    reject_d = 1'b0;
    fault_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Coin is folded in first; cancel then sees the updated credit, and a
        // credit that reaches PRICE takes priority over the cancel.
        reject_d = coin_both;
        credit_d = credit_acc;
        if (credit_acc >= PRICE_C) begin
          state_d = ST_VEND;
          req_d   = 1'b1;
        end else if (cancel) begin
          state_d = (credit_acc == '0) ? ST_IDLE : ST_CHANGE;
        end else if (coin_any && !coin_both) begin
          state_d = ST_COLLECT;
        end
      end
      ST_VEND: begin
        reject_d = coin_any;
        if (dispense_ack) begin
          credit_d = remainder;
          req_d    = 1'b0;
          state_d  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
        end else if (wdog_expire) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        reject_d = coin_any;
        if (credit_q != '0) begin
          pulse_d  = 1'b1;
          credit_d = credit_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        req_d    = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      req_q    <= 1'b0;
      pulse_q  <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      req_q    <= req_d;
      pulse_q  <= pulse_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign dispense_req = req_q;
  assign change_pulse = pulse_q;
  assign coin_reject  = reject_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
`ifdef VEND_TIMEOUT_EN
  assign dispense_fault = fault_q;
`else
  assign dispense_fault = 1'b0;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized
// transactions checked against a credit-level reference model.
module tb_vend_ctrl;

  localparam int unsigned PRICE   = 3;
  localparam int unsigned CW      = 4;
  localparam int unsigned TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          coin_half = 1'b0;
  logic          coin_one = 1'b0;
  logic          cancel = 1'b0;
  logic          dispense_ack = 1'b0;
  logic          dispense_req, change_pulse, coin_reject, busy, dispense_fault;
  logic [CW-1:0] credit;

  int checks   = 0;
  int failures = 0;
  int mcredit  = 0;

  vend_ctrl #(
    .PRICE   (PRICE),
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .coin_half      (coin_half),
    .coin_one       (coin_one),
    .cancel         (cancel),
    .dispense_ack   (dispense_ack),
    .dispense_req   (dispense_req),
    .change_pulse   (change_pulse),
    .coin_reject    (coin_reject),
    .credit         (credit),
    .busy           (busy),
    .dispense_fault (dispense_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic h, input logic o, input logic c, input logic a);
    coin_half = h; coin_one = o; cancel = c; dispense_ack = a;
    @(posedge clk);
    #1;
    coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0; dispense_ack = 1'b0;
  endtask

  // v: 0 none, 1 half, 2 one, 3 both together; only used while not busy.
  task automatic put(input int v, input logic c, input string tag);
    step(v == 1 || v == 3, v == 2 || v == 3, c, 1'b0);
    if (v == 1 || v == 2) mcredit += v;
    chk({tag, " reject"}, coin_reject, v == 3);
    chk({tag, " credit"}, credit, mcredit);
  endtask

  // Count change pulses until busy drops; coins offered meanwhile must bounce.
  task automatic drain(input int exp_n, input string tag);
    int  n;
    bit  done;
    logic h;
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      h = ($urandom_range(0, 2) == 0);
      step(h, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
      if (h) chk({tag, " chg reject"}, coin_reject, 1);
      if (change_pulse === 1'b1) n++;
      if (busy === 1'b0) done = 1;
    end
    chk({tag, " chg done"}, done, 1);
    chk({tag, " pulses"}, n, exp_n);
    chk({tag, " chg credit"}, credit, 0);
    chk({tag, " chg pulse idle"}, change_pulse, 0);
    mcredit = 0;
  endtask

  task automatic vend(input string tag);
    int   d, rem;
    logic h, c;
    chk({tag, " req"}, dispense_req, 1);
    chk({tag, " busy"}, busy, 1);
    d = $urandom_range(0, 4);
    for (int i = 0; i < d; i++) begin
      h = $urandom_range(0, 1) == 1;
      c = $urandom_range(0, 1) == 1;
      step(h, 1'b0, c, 1'b0);
      chk({tag, " vend reject"}, coin_reject, h);
      chk({tag, " vend hold"}, dispense_req, 1);
      chk({tag, " vend credit"}, credit, mcredit);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rem = mcredit - int'(PRICE);
    chk({tag, " ack req"}, dispense_req, 0);
    chk({tag, " ack credit"}, credit, rem);
    chk({tag, " ack busy"}, busy, rem > 0);
    chk({tag, " ack fault"}, dispense_fault, 0);
    mcredit = rem;
    if (rem > 0) drain(rem, tag);
  endtask

  // After a put: follow the model into vend, refund, or continued collection.
  task automatic settle(input logic c, input string tag, output bit ended);
    ended = 1;
    if (mcredit >= int'(PRICE)) begin
      vend(tag);
    end else if (c && mcredit > 0) begin
      chk({tag, " refund busy"}, busy, 1);
      drain(mcredit, tag);
    end else begin
      chk({tag, " collect busy"}, busy, 0);
      ended = c;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " credit"}, credit, 0);
    chk({tag, " req"}, dispense_req, 0);
    chk({tag, " pulse"}, change_pulse, 0);
    chk({tag, " reject"}, coin_reject, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " fault"}, dispense_fault, 0);
  endtask

  initial begin
    bit ended;
    int r, v, k;

    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_reset("rst0");
    rst = 1'b1;

    // Three half coins reach the price exactly.
    put(1, 0, "t1a"); put(1, 0, "t1b"); put(1, 0, "t1c");
    settle(0, "t1", ended);

    // Two full coins overshoot by one half-unit.
    put(2, 0, "t2a"); put(2, 0, "t2b");
    settle(0, "t2", ended);

    // Half coin then cancel refunds a single pulse.
    put(1, 0, "t3a"); put(0, 1, "t3b");
    settle(1, "t3", ended);

    // Coin plus cancel: refund below price, vend at price.
    put(1, 0, "t3c"); put(1, 1, "t3d");
    settle(1, "t3d", ended);
    put(1, 0, "t3e"); put(2, 1, "t3f");
    settle(1, "t3f", ended);

    // Simultaneous coins bounce; ack while idle does nothing.
    put(3, 0, "t4a");
    step(0, 0, 0, 1);
    chk("t4 ack idle credit", credit, 0);
    chk("t4 ack idle busy", busy, 0);

    // Reset during VEND, then during CHANGE.
    put(2, 0, "t6a"); put(2, 0, "t6b");
    chk("t6 in vend", dispense_req, 1);
    rst = 1'b0; step(0, 0, 0, 0); rst = 1'b1;
    chk_reset("t6 rst vend");
    mcredit = 0;
    put(1, 0, "t6c");
    put(1, 1, "t6d");
    step(0, 0, 0, 0);
    chk("t6 in change", change_pulse, 1);
    rst = 1'b0; step(0, 0, 0, 0); rst = 1'b1;
    chk_reset("t6 rst chg");
    mcredit = 0;
    put(1, 0, "t6e");
    put(0, 1, "t6f");
    settle(1, "t6f", ended);

`ifdef VEND_TIMEOUT_EN
    put(2, 0, "t5a"); put(1, 0, "t5b");
    chk("t5 vend", dispense_req, 1);
    k = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      step(0, 0, 0, 0);
      if (dispense_fault === 1'b1) k = i;
    end
    chk("t5 fault cycle", k, TIMEOUT);
    chk("t5 fault req", dispense_req, 0);
    chk("t5 fault credit", credit, 3);
    step(0, 0, 0, 0);
    chk("t5 fault one cycle", dispense_fault, 0);
    chk("t5 first pulse", change_pulse, 1);
    mcredit = 2;
    drain(2, "t5");
    put(2, 0, "t5c"); put(1, 0, "t5d");
    for (int i = 1; i < int'(TIMEOUT); i++) step(0, 0, 0, 0);
    chk("t5 pre-expiry req", dispense_req, 1);
    step(0, 0, 0, 1);
    chk("t5 ack wins fault", dispense_fault, 0);
    chk("t5 ack wins credit", credit, 0);
    chk("t5 ack wins busy", busy, 0);
    mcredit = 0;
`endif

    // Randomized transactions against the credit model.
    for (int t = 0; t < 40; t++) begin
      ended = 0;
      for (int s = 0; s < 20 && !ended; s++) begin
        r = $urandom_range(0, 5);
        v = $urandom_range(1, 2);
        case (r)
          0: begin
            step(0, 0, 0, $urandom_range(0, 1) == 1);
            chk("rnd idle credit", credit, mcredit);
            chk("rnd idle reject", coin_reject, 0);
            chk("rnd idle busy", busy, 0);
          end
          1, 2: begin put(v, 0, "rnd coin"); settle(0, "rnd coin", ended); end
          3:    put(3, 0, "rnd both");
          4:    begin put(0, 1, "rnd cancel"); settle(1, "rnd cancel", ended); end
          default: begin
            if (mcredit > 0) put(v, 1, "rnd coin+cancel");
            else             put(0, 1, "rnd coin+cancel");
            settle(1, "rnd coin+cancel", ended);
          end
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction controller for the coin-operated vending datapath. It accumulates coin credit in 0.5-unit steps and starts a vend once credit reaches PRICE. It sequences a req/ack handshake with the product dispenser, then returns change or a refund as one half-unit pulse per cycle. It sits between the coin acceptor and the dispenser/change hopper, and it owns the credit register.

Parameters:
PRICE, 3, product price in half-units (3 = 1.5); legal range 1..13.
CW, 4, credit width in bits; must hold PRICE+1.
TIMEOUT, 255, cycles to wait for dispense_ack before abort (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-low reset, sampled on rising edge of clk.
coin_half  in  1  one-cycle pulse: 0.5 coin inserted.
coin_one  in  1  one-cycle pulse: 1.0 coin inserted.
cancel  in  1  one-cycle pulse: user requests refund.
dispense_ack  in  1  dispenser done; may arrive any cycle after dispense_req rises.
dispense_req  out  1  level; high from entry into VEND until the ack edge.
change_pulse  out  1  one half-unit returned per high cycle.
coin_reject  out  1  one-cycle pulse: coin not accepted, returned mechanically.
credit  out  CW  current credit in half-units, registered.
busy  out  1  high in VEND or CHANGE.
dispense_fault  out  1  one-cycle pulse on timeout abort (optional feature only).

Behaviour:
- Reset (rst==0 at edge): state=IDLE; credit=0; all outputs 0; any watchdog count=0. Reset overrides everything, including mid-VEND and mid-CHANGE.
- All outputs are registered. Inputs sampled at edge N take effect on outputs after edge N.
- States are one-hot: IDLE, COLLECT, VEND, CHANGE.
- Coin acceptance applies in IDLE and COLLECT only:
  - coin_half adds 1 to credit; coin_one adds 2.
  - Both high in the same cycle: both rejected, coin_reject=1, credit unchanged.
  - Any coin during VEND or CHANGE: coin_reject=1, credit unchanged.
- IDLE -> COLLECT on an accepted coin.
- COLLECT transitions:
  - If the updated credit >= PRICE, go to VEND on the same edge that accepts the coin.
  - cancel with no coin: go to CHANGE (refund), or to IDLE if credit==0.
  - cancel together with a coin: the coin is accepted first, then the cancel is evaluated on the new credit. If that credit >= PRICE, VEND wins and the cancel is ignored.
- VEND:
  - dispense_req=1; cancel is ignored.
  - On dispense_ack: credit -= PRICE, dispense_req=0, next state CHANGE if the remainder >0, else IDLE.
  - The remainder is at most 1 (PRICE+1 is the maximum credit).
- CHANGE: each cycle change_pulse=1 and credit -= 1. When credit reaches 0, go to IDLE with change_pulse=0 on the following cycle. The pulse count always equals the credit held on entry.
- busy=1 exactly while state is VEND or CHANGE.
- dispense_ack outside VEND is ignored.
- Credit never exceeds PRICE+1, so there is no wrap-around.

Optional Feature:
VEND_TIMEOUT_EN.
- Defined: a watchdog counts cycles in VEND.
  - If count reaches TIMEOUT without an ack: dispense_req drops, dispense_fault pulses for one cycle, and the full credit is refunded via CHANGE (no PRICE deduction).
  - An ack on the same edge as the timeout wins (normal vend).
  - The counter clears on leaving VEND.
- Not defined: VEND waits indefinitely, dispense_fault is tied 0, and no counter logic is generated.

Decomposition:
- Package vend_pkg holds:
  - state encoding constants ST_IDLE=4'b0001, ST_COLLECT=4'b0010, ST_VEND=4'b0100, ST_CHANGE=4'b1000;
  - coin value constants HALF_UNITS=1, ONE_UNITS=2.
- One sub-module, vend_wdog: a TIMEOUT counter with clear/enable inputs and an expire output, instantiated only under VEND_TIMEOUT_EN.

Test Plan:
1. Three coin_half pulses on separate cycles -> credit 1,2,3. dispense_req rises after the 3rd edge. Ack -> IDLE, credit 0, no change_pulse.
2. coin_one, coin_one -> credit 2 then 4. VEND entered; ack -> credit 1, exactly one change_pulse, then IDLE.
3. coin_half then cancel -> exactly one change_pulse, credit 0, IDLE. A cancel asserted during VEND has no effect.
4. coin_half and coin_one high in the same cycle -> coin_reject one cycle, credit stays 0. A coin during CHANGE -> coin_reject, pulse count unchanged.
5. With VEND_TIMEOUT_EN: credit 3, ack withheld -> after 255 VEND cycles dispense_fault pulses and 3 change_pulses follow. Ack on the expiry cycle -> normal vend, no fault.
6. rst=0 during CHANGE or VEND -> at the next edge all outputs 0 and state IDLE. After release, a fresh coin_half gives credit 1.
